// File: rtl/spgd_accum_pkg.sv
//------------------------------------------------------------------------------
// spgd_accum_pkg : shared SPGD types, 16Q16 defaults and saturation limits
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package spgd_accum_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_INT_WIDTH  = 16;
  localparam int DEF_N_CH       = 8;

  // 1.0 in the default 16Q16 format
  localparam logic [DEF_DATA_WIDTH-1:0] DEF_ONE = 32'h0001_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } spgd_state_e;

  // Limits are returned in 64 bits; callers keep the low w bits (w <= 64).
  function automatic logic [63:0] sat_max_u64(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min_u64(input int w);
    return ~sat_max_u64(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spgd_accum_sat_add.sv
//------------------------------------------------------------------------------
// sat_add : signed add at DATA_WIDTH+1 bits, clamped back to DATA_WIDTH
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sat_add
  import spgd_accum_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] sum,
  output logic                         sat
);

  localparam logic [63:0] MAX64 = sat_max_u64(DATA_WIDTH);
  localparam logic [63:0] MIN64 = sat_min_u64(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = MAX64[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = MIN64[DATA_WIDTH-1:0];

  logic [DATA_WIDTH:0] wide;

  assign wide = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};

  // Overflow shows up as disagreement between the extra sign bit and the MSB
  always_comb begin
    sat = wide[DATA_WIDTH] ^ wide[DATA_WIDTH-1];
    sum = wide[DATA_WIDTH-1:0];
    if (sat) begin
      sum = wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spgd_accum.sv
//------------------------------------------------------------------------------
// spgd_accum : per-channel saturating SPGD update accumulator, 1-cycle latency
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spgd_accum
  import spgd_accum_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int INT_WIDTH  = DEF_INT_WIDTH,
  parameter int N_CH       = DEF_N_CH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [$clog2(N_CH)-1:0]      out_ch,
  output logic                         frame_done,
  output logic                         sat_flag
);

  localparam int CH_W = $clog2(N_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  generate
    if (DATA_WIDTH < INT_WIDTH || N_CH < 2 || DATA_WIDTH > 64) begin : g_param_check
      $error("spgd_accum: illegal DATA_WIDTH/INT_WIDTH/N_CH combination");
    end
  endgenerate

  spgd_state_e state;
  spgd_state_e state_next;

  logic signed [DATA_WIDTH-1:0] acc [N_CH];
  logic [CH_W-1:0]              ch;
  logic [CH_W-1:0]              clr_idx;
  logic signed [DATA_WIDTH-1:0] upd_sum;
  logic                         upd_sat;
  logic                         xfer;

  assign in_ready = (state != ST_CLEAR) && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;

  sat_add #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sat_add (
    .a   (acc[ch]),
    .b   (in_data),
    .sum (upd_sum),
    .sat (upd_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A clear coinciding with a transfer lets the transfer finish this cycle
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (clear) begin
          state_next = ST_CLEAR;
        end else if (xfer) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (clr_idx == LAST_CH) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        acc[i] <= '0;
      end
      ch         <= '0;
      clr_idx    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      frame_done <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (xfer) begin
        acc[ch]    <= upd_sum;
        out_valid  <= 1'b1;
        out_data   <= upd_sum;
        out_ch     <= ch;
        frame_done <= (ch == LAST_CH);
        sat_flag   <= (ch == '0) ? upd_sat : (sat_flag | upd_sat);
        ch         <= (ch == LAST_CH) ? '0 : ch + CH_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Transfers are blocked in CLEAR, so these writes never collide
      if (state == ST_CLEAR) begin
        acc[clr_idx] <= '0;
        if (clr_idx == LAST_CH) begin
          clr_idx  <= '0;
          ch       <= '0;
          sat_flag <= 1'b0;
        end else begin
          clr_idx <= clr_idx + CH_W'(1);
        end
      end else begin
        clr_idx <= '0;
      end
    end
  end

endmodule

`default_nettype wire
